inst_encode_loader: RTL and testbench

- Inverse of the core's immediate decode path. Accepts decoded instruction fields (format, opcode, funct, registers, 32-bit immediate) over a valid/ready handshake.
- Scatters the immediate into RV32I I/S/B/R encodings and writes the 32-bit words into instruction memory at sequential word addresses.
- Used by bench and boot logic to load programs without hand-assembled hex.

---
 rtl/inst_encode_loader_if.sv | 29 ++
 rtl/inst_encode_loader.sv | 145 ++++++++++++++
 tb/tb_inst_encode_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encode_loader_if.sv
// Field-bundle handshake from the program source plus the instruction-memory write bus.
// The loader sits on the slave side, and whoever feeds it programs sits on the master side.
interface inst_encode_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            fmt;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   logic [4:0]            rd;
   logic [4:0]            rs1;
   logic [4:0]            rs2;
   logic [31:0]           imm;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   modport master (
      output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/inst_encode_loader.sv
// Packs decoded RV32I fields back into instruction words and streams them into
// instruction memory at sequential word addresses. Out-of-range immediates are dropped and flagged.
module inst_encode_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   inst_encode_loader_if.slave   bus,
   output logic [ADDR_WIDTH:0]   words_written,
   output logic                  full,
   output logic                  err_imm
);

   typedef enum logic [1:0] {IDLE, LOAD, FULL} stateT;

   localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

   stateT                 state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full_q, full_d;
   logic                  err_q, err_d;
   logic                  memWe_q, memWe_d;
   logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
   logic [31:0]           wData_q, wData_d;

   logic [31:0]           encWord;
   logic                  immOk;
   logic                  accept;

   // Scatter the immediate into the format's bit positions and check it fits that format.
   always_comb begin
      encWord = 32'd0;
      immOk   = 1'b1;
      unique case (bus.fmt)
         2'd0: begin
            encWord = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            immOk   = (&bus.imm[31:11]) || ~(|bus.imm[31:11]);
         end
         2'd1: begin
            encWord = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            immOk   = (&bus.imm[31:11]) || ~(|bus.imm[31:11]);
         end
         2'd2: begin
            encWord = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                       bus.imm[4:1], bus.imm[11], bus.opcode};
            immOk   = ((&bus.imm[31:12]) || ~(|bus.imm[31:12])) && !bus.imm[0];
         end
         default: begin
            encWord = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            immOk   = 1'b1;
         end
      endcase
   end

   assign accept = bus.in_valid && (state_q == LOAD);

   // A write to the last address parks the loader and latches full, even if stop arrives in the same cycle.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      count_d   = count_q;
      full_d    = full_q;
      err_d     = err_q;
      memWe_d   = 1'b0;
      memAddr_d = memAddr_q;
      wData_d   = wData_q;
      unique case (state_q)
         IDLE: begin
            if (clear) begin
               addr_d  = ADDR_BASE;
               count_d = '0;
               err_d   = 1'b0;
               full_d  = 1'b0;
            end
            if (start && !full_q) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               if (immOk) begin
                  memWe_d   = 1'b1;
                  memAddr_d = addr_q;
                  wData_d   = encWord;
                  count_d   = count_q + (ADDR_WIDTH + 1)'(1);
                  if (addr_q == ADDR_LAST) begin
                     full_d  = 1'b1;
                     state_d = FULL;
                  end else begin
                     addr_d = addr_q + ADDR_WIDTH'(1);
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
            if (stop) begin
               state_d = IDLE;
            end
         end
         default: begin
            if (stop) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   // State and datapath registers, all cleared synchronously.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= ADDR_BASE;
         count_q   <= '0;
         full_q    <= 1'b0;
         err_q     <= 1'b0;
         memWe_q   <= 1'b0;
         memAddr_q <= '0;
         wData_q   <= 32'd0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         full_q    <= full_d;
         err_q     <= err_d;
         memWe_q   <= memWe_d;
         memAddr_q <= memAddr_d;
         wData_q   <= wData_d;
      end
   end

   assign bus.in_ready  = (state_q == LOAD);
   assign bus.mem_we    = memWe_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wdata = wData_q;
   assign words_written = count_q;
   assign full          = full_q;
   assign err_imm       = err_q;

endmodule

// File: tb/tb_inst_encode_loader.sv
// Directed bench for inst_encode_loader: a table of single-bundle encodings plus
// hand-written sequences for back-to-back writes, range errors, capacity and reset.
module tb_inst_encode_loader;

   localparam int AW = 2;

   typedef struct {
      logic [1:0]  fmt;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic        expWe;
      logic [31:0] expWord;
   } vecT;

   logic          clk = 1'b0;
   logic          rst, start, stop, clear;
   logic [AW:0]   words_written;
   logic          full, err_imm;
   int            checks = 0;
   int            failures = 0;
   vecT           vecs[12];
   vecT           v;
   logic [31:0]   lastWord;

   inst_encode_loader_if #(.ADDR_WIDTH(AW)) bus ();

   inst_encode_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .clear         (clear),
      .bus           (bus),
      .words_written (words_written),
      .full          (full),
      .err_imm       (err_imm)
   );

   always #5 clk = ~clk;

   // Outputs are sampled 1ns after each rising edge; inputs change at the same point.
   task tick;
      @(posedge clk);
      #1;
   endtask

   task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task applyStimulus(input vecT s);
      bus.fmt    = s.fmt;
      bus.opcode = s.opcode;
      bus.funct3 = s.f3;
      bus.funct7 = s.f7;
      bus.rd     = s.rd;
      bus.rs1    = s.rs1;
      bus.rs2    = s.rs2;
      bus.imm    = s.imm;
   endtask

   task restartLoad;
      stop = 1'b1;  tick; stop = 1'b0;
      clear = 1'b1; tick; clear = 1'b0;
      start = 1'b1; tick; start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{2'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,        1'b1, 32'h00500093};
      vecs[1]  = '{2'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0020A423};
      vecs[2]  = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3};
      vecs[3]  = '{2'd3, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 1'b1, 32'h002081B3};
      vecs[4]  = '{2'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b0, 32'h0};
      vecs[5]  = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,        1'b0, 32'h0};
      vecs[6]  = '{2'd0, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b1, 32'h80000093};
      vecs[7]  = '{2'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'h000007FF, 1'b1, 32'h7E20AFA3};
      vecs[8]  = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'h00000FFE, 1'b1, 32'h7E208FE3};
      vecs[9]  = '{2'd2, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF000, 1'b1, 32'h80208063};
      vecs[10] = '{2'd1, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFF7FF, 1'b0, 32'h0};
      vecs[11] = '{2'd3, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hFFFF0000, 1'b1, 32'h402081B3};

      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      bus.in_valid = 1'b0;
      applyStimulus(vecs[0]);
      tick; tick;
      rst = 1'b0;
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
      checkOutput("rst_words", 32'(words_written), 32'd0);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_err", 32'(err_imm), 32'd0);

      // One bundle per fresh session: every legal word lands at address 0.
      lastWord = 32'd0;
      for (int i = 0; i < 12; i++) begin
         restartLoad;
         checkOutput($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'd1);
         applyStimulus(vecs[i]);
         bus.in_valid = 1'b1;
         tick;
         bus.in_valid = 1'b0;
         if (vecs[i].expWe) lastWord = vecs[i].expWord;
         checkOutput($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].expWe));
         checkOutput($sformatf("vec%0d_wdata", i), bus.mem_wdata, lastWord);
         checkOutput($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'd0);
         checkOutput($sformatf("vec%0d_words", i), 32'(words_written), 32'(vecs[i].expWe));
         checkOutput($sformatf("vec%0d_err", i), 32'(err_imm), 32'(!vecs[i].expWe));
         tick;
         checkOutput($sformatf("vec%0d_we_drop", i), 32'(bus.mem_we), 32'd0);
      end

      // Back-to-back S then B accepts give back-to-back writes.
      restartLoad;
      applyStimulus(vecs[1]);
      bus.in_valid = 1'b1;
      tick;
      checkOutput("b2b_we0", 32'(bus.mem_we), 32'd1);
      checkOutput("b2b_addr0", 32'(bus.mem_addr), 32'd0);
      checkOutput("b2b_data0", bus.mem_wdata, 32'h0020A423);
      applyStimulus(vecs[2]);
      tick;
      bus.in_valid = 1'b0;
      checkOutput("b2b_we1", 32'(bus.mem_we), 32'd1);
      checkOutput("b2b_addr1", 32'(bus.mem_addr), 32'd1);
      checkOutput("b2b_data1", bus.mem_wdata, 32'hFE208EE3);
      checkOutput("b2b_words", 32'(words_written), 32'd2);
      tick;
      checkOutput("b2b_we_idle", 32'(bus.mem_we), 32'd0);
      checkOutput("b2b_addr_hold", 32'(bus.mem_addr), 32'd1);
      checkOutput("b2b_data_hold", bus.mem_wdata, 32'hFE208EE3);

      // Rejected immediates consume the bundle but leave the address alone.
      restartLoad;
      bus.in_valid = 1'b1;
      applyStimulus(vecs[4]);
      tick;
      checkOutput("err_i_we", 32'(bus.mem_we), 32'd0);
      checkOutput("err_i_flag", 32'(err_imm), 32'd1);
      applyStimulus(vecs[5]);
      tick;
      checkOutput("err_b_we", 32'(bus.mem_we), 32'd0);
      applyStimulus(vecs[0]);
      tick;
      bus.in_valid = 1'b0;
      checkOutput("err_next_we", 32'(bus.mem_we), 32'd1);
      checkOutput("err_next_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("err_next_data", bus.mem_wdata, 32'h00500093);
      checkOutput("err_sticky", 32'(err_imm), 32'd1);
      checkOutput("err_words", 32'(words_written), 32'd1);
      stop = 1'b1;  tick; stop = 1'b0;
      checkOutput("err_stop_sticky", 32'(err_imm), 32'd1);
      clear = 1'b1; tick; clear = 1'b0;
      checkOutput("err_cleared", 32'(err_imm), 32'd0);
      checkOutput("err_words_cleared", 32'(words_written), 32'd0);

      // Capacity: four words fill a 2-bit address space, the fifth is held off.
      restartLoad;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         v = vecs[0];
         v.imm = 32'(k);
         applyStimulus(v);
         checkOutput($sformatf("full_ready%0d", k), 32'(bus.in_ready), 32'd1);
         tick;
         checkOutput($sformatf("full_we%0d", k), 32'(bus.mem_we), 32'd1);
         checkOutput($sformatf("full_addr%0d", k), 32'(bus.mem_addr), 32'(k));
         checkOutput($sformatf("full_data%0d", k), bus.mem_wdata, (32'(k) << 20) | 32'h93);
      end
      checkOutput("full_ready_after", 32'(bus.in_ready), 32'd0);
      checkOutput("full_flag", 32'(full), 32'd1);
      checkOutput("full_words", 32'(words_written), 32'd4);
      tick;
      bus.in_valid = 1'b0;
      checkOutput("full_fifth_we", 32'(bus.mem_we), 32'd0);
      checkOutput("full_fifth_words", 32'(words_written), 32'd4);
      stop = 1'b1;  tick; stop = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      checkOutput("full_restart_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("full_restart_flag", 32'(full), 32'd1);
      clear = 1'b1; tick; clear = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      checkOutput("full_cleared_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("full_cleared_flag", 32'(full), 32'd0);
      checkOutput("full_cleared_words", 32'(words_written), 32'd0);

      // Reset right after an accept drops everything.
      applyStimulus(vecs[0]);
      bus.in_valid = 1'b1;
      tick;
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checkOutput("rstfly_we", 32'(bus.mem_we), 32'd0);
      checkOutput("rstfly_words", 32'(words_written), 32'd0);
      checkOutput("rstfly_ready", 32'(bus.in_ready), 32'd0);

      // start+stop together: LOAD honours stop, IDLE honours start.
      start = 1'b1; tick; start = 1'b0;
      start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
      checkOutput("ss_load_to_idle", 32'(bus.in_ready), 32'd0);
      start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
      checkOutput("ss_idle_to_load", 32'(bus.in_ready), 32'd1);

      // Accept with a coincident stop still writes, then idles.
      applyStimulus(vecs[3]);
      bus.in_valid = 1'b1; stop = 1'b1;
      tick;
      bus.in_valid = 1'b0; stop = 1'b0;
      checkOutput("stopacc_we", 32'(bus.mem_we), 32'd1);
      checkOutput("stopacc_data", bus.mem_wdata, 32'h002081B3);
      checkOutput("stopacc_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("stopacc_words", 32'(words_written), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
